// File: rtl/vga_pkg.sv
// Shared definitions for the VGA framebuffer arbiter slice.
// Holds the display geometry, the framebuffer size, the default arbiter
// parameters, the palette index type and the arbiter state encoding.
package vga_pkg;

  localparam int unsigned H_ACTIVE   = 640;
  localparam int unsigned V_ACTIVE   = 480;
  localparam int unsigned FB_WORDS   = H_ACTIVE * V_ACTIVE;  // 307200
  localparam int unsigned ADDR_W     = 24;
  localparam int unsigned PIX_W      = 4;
  localparam int unsigned FIFO_DEPTH = 16;
  localparam int unsigned LOW_WATER  = 4;

  typedef logic [3:0] pix_t;

  typedef enum logic [1:0] {
    WAIT_FRAME,
    PREFILL,
    ACTIVE,
    DONE
  } fb_arb_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous first-word-fall-through FIFO for prefetched palette indices.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   flush       discard all entries (takes priority over push/pop)
//   push/wdata  write one entry (ignored when full unless popping too)
//   pop         remove the head entry (ignored when empty)
//   rdata       current head entry, valid whenever empty is low
//   count       number of stored entries (0..DEPTH)
//   full/empty  occupancy flags
module pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer RAM between VGA scan-out prefetch and
// CPU pixel writes. Scan-out pixels are fetched in raster order into a
// small FWFT FIFO; the CPU only gets RAM cycles the display can spare.
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   frame_start             restarts fetching for a new frame
//   pix_req                 display consumes one pixel this cycle
//   pix_data, pix_valid     popped palette index / came from FIFO
//   underflow               sticky: pixel requested while FIFO empty
//   cpu_req/addr/wdata      CPU write request, held until cpu_gnt
//   cpu_gnt                 write issued to RAM this cycle
//   mem_addr/we/wdata       RAM command port
//   mem_rdata               RAM read data, one cycle after the address
module vga_fb_arbiter #(
  parameter int unsigned H_ACTIVE   = vga_pkg::H_ACTIVE,
  parameter int unsigned V_ACTIVE   = vga_pkg::V_ACTIVE,
  parameter int unsigned ADDR_W     = vga_pkg::ADDR_W,
  parameter int unsigned PIX_W      = vga_pkg::PIX_W,
  parameter int unsigned FIFO_DEPTH = vga_pkg::FIFO_DEPTH,
  parameter int unsigned LOW_WATER  = vga_pkg::LOW_WATER
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_start,
  input  logic              pix_req,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  output logic              underflow,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [PIX_W-1:0]  cpu_wdata,
  output logic              cpu_gnt,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [PIX_W-1:0]  mem_wdata,
  input  logic [PIX_W-1:0]  mem_rdata
);

  import vga_pkg::*;

  localparam int unsigned    CNT_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [18:0]    FETCH_END = 19'(H_ACTIVE * V_ACTIVE);
  localparam logic [CNT_W:0] LVL_FULL  = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0] LVL_LOW   = (CNT_W+1)'(LOW_WATER);

  fb_arb_state_t     state;
  fb_arb_state_t     state_nx;
  logic [18:0]       fetch_ptr;
  logic              inflight;
  logic [ADDR_W-1:0] addr_hold;
  logic              do_fetch;
  logic              do_cpu;
  logic              fetch_done;
  logic              cpu_in_range;

  logic [PIX_W-1:0]  fifo_head;
  logic [CNT_W-1:0]  occ;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic [CNT_W:0]    level;

  // Occupancy plus the read still in flight: the guard that keeps the
  // FIFO from ever receiving more data than it can hold.
  assign level        = {1'b0, occ} + {{CNT_W{1'b0}}, inflight};
  assign fetch_done   = (fetch_ptr == FETCH_END);
  assign cpu_in_range = (cpu_addr < ADDR_W'(H_ACTIVE * V_ACTIVE));

  // frame_start flushes the FIFO, so neither the returning read nor a
  // display pop may touch it in that cycle.
  assign fifo_push = inflight && !frame_start && (!fifo_full || fifo_pop);
  assign fifo_pop  = rst_n && pix_req && !frame_start && !fifo_empty;

  pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (PIX_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (frame_start),
    .push  (fifo_push),
    .wdata (mem_rdata),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .count (occ),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Next state and per-cycle RAM slot arbitration. RAM commands are
  // suppressed while rst_n is low so a reset never overlaps a write.
  always_comb begin
    state_nx = state;
    do_fetch = 1'b0;
    do_cpu   = 1'b0;
    if (!rst_n) begin
      state_nx = state;
    end else if (frame_start) begin
      state_nx = PREFILL;
    end else begin
      case (state)
        WAIT_FRAME: do_cpu = cpu_req;
        PREFILL: begin
          if (level == LVL_FULL || fetch_done) begin
            state_nx = ACTIVE;
          end else begin
            do_fetch = 1'b1;
          end
        end
        ACTIVE: begin
          if (fetch_done) state_nx = DONE;
          if (!fetch_done && level < LVL_LOW) begin
            do_fetch = 1'b1;
          end else if (cpu_req) begin
            do_cpu = 1'b1;
          end else if (!fetch_done && level < LVL_FULL) begin
            do_fetch = 1'b1;
          end
        end
        DONE:    do_cpu = cpu_req;
        default: state_nx = WAIT_FRAME;
      endcase
    end
  end

  always_comb begin
    mem_addr = addr_hold;
    if (do_fetch)    mem_addr = ADDR_W'(fetch_ptr);
    else if (do_cpu) mem_addr = cpu_addr;
  end

  assign mem_we    = do_cpu && cpu_in_range;
  assign mem_wdata = do_cpu ? cpu_wdata : '0;
  assign cpu_gnt   = do_cpu;
  assign pix_valid = fifo_pop;
  assign pix_data  = fifo_pop ? fifo_head : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= WAIT_FRAME;
      fetch_ptr <= '0;
      inflight  <= 1'b0;
      underflow <= 1'b0;
      addr_hold <= '0;
    end else begin
      state     <= state_nx;
      inflight  <= do_fetch;
      addr_hold <= mem_addr;
      if (frame_start) begin
        fetch_ptr <= '0;
        underflow <= 1'b0;
      end else begin
        if (do_fetch)               fetch_ptr <= fetch_ptr + 19'd1;
        if (pix_req && fifo_empty)  underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter on a reduced 32x16 raster. A RAM
// model answers the DUT's memory port; the expected picture is kept as an
// image array updated with every in-range CPU write, and scan-out must
// deliver it in raster order.
module tb_vga_fb_arbiter;

  localparam int unsigned H     = 32;
  localparam int unsigned V     = 16;
  localparam int unsigned FB    = H * V;
  localparam int unsigned AW    = 24;
  localparam int unsigned PW    = 4;
  localparam int unsigned DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          frame_start = 1'b0;
  logic          pix_req = 1'b0;
  logic          cpu_req = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [PW-1:0] cpu_wdata = '0;
  logic [PW-1:0] pix_data;
  logic          pix_valid;
  logic          underflow;
  logic          cpu_gnt;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [PW-1:0] mem_wdata;
  logic [PW-1:0] mem_rdata = '0;

  logic [PW-1:0] ram [FB];
  logic [PW-1:0] img [FB];
  logic          load = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .ADDR_W     (AW),
    .PIX_W      (PW),
    .FIFO_DEPTH (DEPTH),
    .LOW_WATER  (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .pix_req     (pix_req),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underflow   (underflow),
    .cpu_req     (cpu_req),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_gnt     (cpu_gnt),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  // Single-port RAM: write on mem_we, read data one cycle after address.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < FB; i++) ram[i] <= img[i];
    end else if (mem_we && mem_addr < AW'(FB)) begin
      ram[mem_addr[8:0]] <= mem_wdata;
    end
    mem_rdata <= (mem_addr < AW'(FB)) ? ram[mem_addr[8:0]] : '0;
  end

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #4;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pix_data"},  32'(pix_data), 32'd0);
    chk({tag, "_pix_valid"}, 32'(pix_valid), 32'd0);
    chk({tag, "_underflow"}, 32'(underflow), 32'd0);
    chk({tag, "_cpu_gnt"},   32'(cpu_gnt), 32'd0);
    chk({tag, "_mem_we"},    32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
  endtask

  initial begin
    int          popped;
    int          gnt_at;
    int unsigned a;
    logic [PW-1:0] d;

    for (int i = 0; i < FB; i++) img[i] = PW'($urandom_range(0, 15));

    // Reset with the RAM image loaded
    load = 1'b1;
    next();
    load = 1'b0;
    next();
    settle();
    chk_reset_outputs("reset");
    next();
    rst_n = 1'b1;

    // WAIT_FRAME: CPU granted immediately
    d = PW'($urandom_range(0, 15));
    cpu_req = 1'b1; cpu_addr = AW'(5); cpu_wdata = d;
    settle();
    chk("wf_gnt", 32'(cpu_gnt), 32'd1);
    chk("wf_we", 32'(mem_we), 32'd1);
    chk("wf_addr", 32'(mem_addr), 32'd5);
    chk("wf_wdata", 32'(mem_wdata), 32'(d));
    img[5] = d;
    next();
    cpu_req = 1'b0;

    // Frame 1: prefill fetches 0..15, then idle with the FIFO full
    frame_start = 1'b1;
    settle();
    chk("fs1_gnt", 32'(cpu_gnt), 32'd0);
    chk("fs1_we", 32'(mem_we), 32'd0);
    next();
    frame_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      settle();
      chk("pf_addr", 32'(mem_addr), 32'(i));
      chk("pf_we", 32'(mem_we), 32'd0);
      chk("pf_gnt", 32'(cpu_gnt), 32'd0);
      next();
    end
    for (int i = 0; i < 10; i++) begin
      settle();
      chk("full_hold_addr", 32'(mem_addr), 32'd15);
      chk("full_we", 32'(mem_we), 32'd0);
      next();
    end

    // Whole frame consumed every cycle while a CPU write competes
    img[256] = 4'h7;
    cpu_req = 1'b1; cpu_addr = 24'h000100; cpu_wdata = 4'h7;
    pix_req = 1'b1;
    popped = 0;
    gnt_at = -1;
    for (int c = 0; c < FB; c++) begin
      settle();
      chk("frm_valid", 32'(pix_valid), 32'd1);
      chk("frm_data", 32'(pix_data), 32'(img[popped]));
      popped++;
      if (cpu_gnt && gnt_at < 0) begin
        gnt_at = c;
        chk("frm_gnt_we", 32'(mem_we), 32'd1);
        chk("frm_gnt_addr", 32'(mem_addr), 32'h100);
      end
      next();
      if (gnt_at >= 0) cpu_req = 1'b0;
    end
    pix_req = 1'b0;
    cpu_req = 1'b0;
    settle();
    chk("frm_gnt_latency", 32'(gnt_at >= 0 && gnt_at < 16), 32'd1);
    chk("frm_underflow", 32'(underflow), 32'd0);
    chk("frm_ram_100", 32'(ram[256]), 32'h7);
    next();

    // DONE: back-to-back writes granted every cycle
    for (int i = 0; i < 6; i++) begin
      a = $urandom_range(0, FB - 1);
      d = PW'($urandom_range(0, 15));
      cpu_req = 1'b1; cpu_addr = AW'(a); cpu_wdata = d;
      settle();
      chk("done_gnt", 32'(cpu_gnt), 32'd1);
      chk("done_we", 32'(mem_we), 32'd1);
      chk("done_addr", 32'(mem_addr), a);
      chk("done_wdata", 32'(mem_wdata), 32'(d));
      img[a] = d;
      next();
    end
    cpu_addr = AW'(FB);
    settle();
    chk("oor_gnt", 32'(cpu_gnt), 32'd1);
    chk("oor_we", 32'(mem_we), 32'd0);
    next();
    cpu_req = 1'b0;

    // Frame 2: let the FIFO fill, then restart with everything colliding
    frame_start = 1'b1;
    next();
    frame_start = 1'b0;
    repeat (24) next();
    frame_start = 1'b1; pix_req = 1'b1;
    cpu_req = 1'b1; cpu_addr = AW'(3); cpu_wdata = 4'h1;
    settle();
    chk("fsx_gnt", 32'(cpu_gnt), 32'd0);
    chk("fsx_valid", 32'(pix_valid), 32'd0);
    chk("fsx_data", 32'(pix_data), 32'd0);
    chk("fsx_we", 32'(mem_we), 32'd0);
    next();
    frame_start = 1'b0; pix_req = 1'b0;
    settle();
    chk("fsx_ptr0", 32'(mem_addr), 32'd0);
    chk("fsx_pf_we", 32'(mem_we), 32'd0);
    chk("fsx_pf_gnt", 32'(cpu_gnt), 32'd0);
    chk("fsx_uf_clear", 32'(underflow), 32'd0);
    next();
    cpu_req = 1'b0; pix_req = 1'b1;
    settle();
    chk("early_valid", 32'(pix_valid), 32'd0);
    chk("early_data", 32'(pix_data), 32'd0);
    next();
    pix_req = 1'b0;
    settle();
    chk("uf_set", 32'(underflow), 32'd1);
    repeat (20) next();
    settle();
    chk("uf_sticky", 32'(underflow), 32'd1);
    next();
    pix_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      settle();
      chk("f2_valid", 32'(pix_valid), 32'd1);
      chk("f2_data", 32'(pix_data), 32'(img[i]));
      next();
    end
    pix_req = 1'b0;

    // One-cycle reset in ACTIVE
    rst_n = 1'b0; pix_req = 1'b1;
    cpu_req = 1'b1; cpu_addr = AW'(9); cpu_wdata = 4'h2;
    next();
    rst_n = 1'b1; pix_req = 1'b0; cpu_req = 1'b0;
    settle();
    chk_reset_outputs("midrst");
    next();
    a = $urandom_range(0, FB - 1);
    d = PW'($urandom_range(0, 15));
    cpu_req = 1'b1; cpu_addr = AW'(a); cpu_wdata = d; pix_req = 1'b1;
    settle();
    chk("post_rst_gnt", 32'(cpu_gnt), 32'd1);
    chk("post_rst_we", 32'(mem_we), 32'd1);
    chk("post_rst_valid", 32'(pix_valid), 32'd0);
    next();
    cpu_req = 1'b0; pix_req = 1'b0;
    next();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
